result_mem_ctrl: RTL and testbench
==================================

// Module: result_mem_ctrl
// PURPOSE
//  Parametrised successor to the single-writer shortest-path result memory (distance/prev-node output RAM).
//  Accepts result writes from NUM_CH engine channels. Each channel has its own FIFO; a round-robin arbiter commits one write per cycle.
//  Serves a host read port with 1-cycle latency. Adds a sweep-clear mode (preload "infinity") and a flush/drain handshake.
//  Sits between the datapath result writers and the host read-out port (output_address/final_output path).
// PARAMETERS
//  DATA_W      16       result word width
//  ADDR_W      14       address width; DEPTH = 2**ADDR_W words
//  NUM_CH      2        number of write channels (1..8)
//  FIFO_DEPTH  4        entries per channel FIFO (power of 2, >=2)
//  CLEAR_VAL   16'hFFFF value written by a clear sweep (unreached node)
//  CLEAR_ON_RST 1       1: enter CLEAR automatically after reset release
// PORTS
//  clock        in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low reset
//  wr_valid     in   NUM_CH          per-channel write request
//  wr_ready     out  NUM_CH          per-channel FIFO can accept
//  wr_addr      in   NUM_CH*ADDR_W   channel c at [c*ADDR_W +: ADDR_W]
//  wr_data      in   NUM_CH*DATA_W   channel c at [c*DATA_W +: DATA_W]
//  rd_req       in   1               host read request
//  rd_addr      in   ADDR_W          host read address
//  rd_valid     out  1               rd_data valid (one-cycle pulse)
//  rd_data      out  DATA_W          read result
//  clear        in   1               start sweep-clear (level, sampled in RUN)
//  flush        in   1               request drain of all FIFOs
//  flush_done   out  1               one-cycle pulse: all FIFOs empty after flush
//  busy         out  1               high in CLEAR or DRAIN
// BEHAVIOUR
//  Reset (async, reset=0):
//   - FIFOs empty; rr pointer=0; wr_ready=0; rd_valid=0; rd_data=0; flush_done=0; busy=0.
//   - State: IDLE. Memory contents are not reset.
//   - On release: IDLE->CLEAR if CLEAR_ON_RST=1, else IDLE->RUN.
//  States:
//   - RUN: normal operation. clear=1 -> CLEAR (only when all FIFOs are empty, else wait in RUN). flush=1 -> DRAIN.
//   - CLEAR: sweep counter 0..DEPTH-1, one CLEAR_VAL write per cycle; takes exactly DEPTH cycles, then -> RUN.
//       wr_ready=0, rd_req ignored (rd_valid stays 0), busy=1.
//   - DRAIN: wr_ready=0, busy=1, arbiter keeps committing. When all FIFOs are empty, pulse flush_done for one cycle -> RUN.
//  Write channels:
//   - Handshake = wr_valid & wr_ready at a rising edge pushes {addr,data} into FIFO c.
//   - wr_ready[c] = (state==RUN) & ~full[c]; it is registered-free, combinational from FIFO count.
//   - Push and pop on a full FIFO in the same cycle are not allowed: ready is low when full.
//  Arbiter:
//   - Each cycle in RUN/DRAIN, grant the first non-empty FIFO at or after rr_ptr (mod NUM_CH).
//   - Pop its head and write it to memory at that edge; rr_ptr <= grant+1 (wraps at NUM_CH). No grant -> rr_ptr holds.
//   - Throughput: 1 commit/cycle total. Per-FIFO commit order is FIFO order.
//   - Same address from two channels: the later grant wins.
//  Read port:
//   - rd_req sampled in RUN/DRAIN. rd_data/rd_valid are registered the next cycle (latency 1). A new request is accepted every cycle.
//   - Read and commit at the same address in the same cycle -> write-first: rd_data returns the committed data.
//   - Entries still in a FIFO are not visible to reads. Host must flush before a coherent read-out.
//  Mid-operation reset: pending FIFO writes are discarded. An interrupted CLEAR leaves memory partially cleared.
// TESTING (bench: ADDR_W=6, NUM_CH=2, FIFO_DEPTH=4, CLEAR_ON_RST=1)
//  1. Release reset -> busy=1 for exactly 64 cycles; then reading addr 0..63 returns 16'hFFFF, each with rd_valid one cycle after rd_req.
//  2. ch0 writes (5,0x0011), ch1 writes (9,0x0022) same cycle -> commits in order ch0 then ch1; flush -> flush_done pulse; read 5->0x0011, 9->0x0022.
//  3. Both channels write addr 7 (ch0 0xAAAA, ch1 0xBBBB) same cycle, rr_ptr=0 -> final read of 7 = 0xBBBB.
//  4. ch0 pushes 6 back-to-back while ch1 is also busy -> wr_ready[0] drops after 4 pending; commits alternate ch0/ch1; no write lost.
//  5. rd_req addr 3 in the same cycle the arbiter commits (3,0x1234) -> next-cycle rd_data=0x1234.
//  6. Assert reset with 3 entries pending and mid-CLEAR -> all outputs go to reset values immediately; pending writes are never committed.

Source files
------------

// File: rtl/result_mem_ctrl.sv
// result_mem_ctrl
//    Result memory (distance / prev-node words) shared by NUM_CH engine write
//    channels and one host read port. Each channel feeds a small FIFO; a
//    round-robin arbiter commits at most one buffered write per cycle. A sweep
//    mode preloads every word with CLEAR_VAL, and a flush/drain handshake lets
//    the host wait until every buffered write has reached the memory.
//
//    Write handshake: a word transfers on channel c at a rising clock edge
//    exactly when wr_valid[c] and wr_ready[c] are both high at that edge. The
//    writer must hold wr_valid/wr_addr/wr_data stable until the transfer.
//    wr_ready[c] is combinational from the controller state and the FIFO
//    fill level only; it never depends on wr_valid.
module result_mem_ctrl #(
   parameter int                DATA_W       = 16,
   parameter int                ADDR_W       = 14,
   parameter int                NUM_CH       = 2,
   parameter int                FIFO_DEPTH   = 4,
   parameter logic [DATA_W-1:0] CLEAR_VAL    = 16'hFFFF,
   parameter bit                CLEAR_ON_RST = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          wr_valid,
   output logic [NUM_CH-1:0]          wr_ready,
   input  logic [NUM_CH*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_CH*DATA_W-1:0]   wr_data,
   input  logic                       rd_req,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   input  logic                       clear,
   input  logic                       flush,
   output logic                       flush_done,
   output logic                       busy,
   output logic [1:0]                 state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CLEAR = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Control strobes decoded from the state
   logic accept_wr;   // channels may push into their FIFOs
   logic arb_en;      // arbiter may commit FIFO heads to memory
   logic rd_en;       // host read requests are honoured

   // Per-channel FIFO status and head entries, flattened by channel
   logic [NUM_CH-1:0]        empty;
   logic [NUM_CH-1:0]        full;
   logic [NUM_CH*ADDR_W-1:0] head_addr;
   logic [NUM_CH*DATA_W-1:0] head_data;
   logic                     all_empty;

   // Arbiter
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   cand;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;
   logic [ADDR_W-1:0] commit_addr;
   logic [DATA_W-1:0] commit_data;

   // Clear sweep and memory write port
   logic [ADDR_W-1:0] sweep;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   assign all_empty = &empty;
   assign state_dbg = state;

   // ------------------------------------------------------------------
   // Per-channel FIFOs. Storage is not reset; only pointers and counts are,
   // which is what discards pending writes on a mid-operation reset.
   // ------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
      logic [DATA_W-1:0] q_data [FIFO_DEPTH];
      logic [PTR_W-1:0]  wptr;
      logic [PTR_W-1:0]  rptr;
      logic [CNT_W-1:0]  cnt;
      logic              push;
      logic              pop;

      assign full[c]     = (cnt == CNT_W'(FIFO_DEPTH));
      assign empty[c]    = (cnt == '0);
      assign wr_ready[c] = accept_wr & ~full[c];
      assign push        = wr_valid[c] & wr_ready[c];
      assign pop         = grant_vld & (grant_idx == CH_W'(c));

      assign head_addr[c*ADDR_W +: ADDR_W] = q_addr[rptr];
      assign head_data[c*DATA_W +: DATA_W] = q_data[rptr];

      // Capture the accepted {addr,data} at the write pointer
      always_ff @(posedge clock) begin
         if (push) begin
            q_addr[wptr] <= wr_addr[c*ADDR_W +: ADDR_W];
            q_data[wptr] <= wr_data[c*DATA_W +: DATA_W];
         end
      end

      // Pointer and occupancy bookkeeping; ready is low when full, so a
      // push and pop on a full FIFO never coincide
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   // Round-robin pick: first non-empty FIFO at or after rr_ptr, then mux its head
   always_comb begin
      grant_vld   = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      commit_addr = '0;
      commit_data = '0;
      if (arb_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!grant_vld && !empty[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant_idx == CH_W'(c)) begin
            commit_addr = head_addr[c*ADDR_W +: ADDR_W];
            commit_data = head_data[c*DATA_W +: DATA_W];
         end
      end
   end

   // Advance the round-robin pointer past the channel just served
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Sweep address: counts through every word while clearing, parked at 0 otherwise
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sweep <= '0;
      end else if (state == S_CLEAR) begin
         sweep <= sweep + 1'b1;
      end else begin
         sweep <= '0;
      end
   end

   // Single memory write port: sweep writes in CLEAR, arbiter commits otherwise
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = sweep;
         mem_wdata = CLEAR_VAL;
      end else if (grant_vld) begin
         mem_we    = 1'b1;
         mem_waddr = commit_addr;
         mem_wdata = commit_data;
      end
   end

   // Result memory array, contents survive reset
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Host read port: one-cycle latency, write-first against a same-cycle commit
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req & rd_en;
         if (rd_req && rd_en) begin
            rd_data <= (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : mem[rd_addr];
         end
      end
   end

   // Controller state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and state-decoded strobes. clear waits in RUN until every
   // FIFO is empty so that no buffered write lands on top of the sweep.
   always_comb begin
      state_nxt  = state;
      accept_wr  = 1'b0;
      arb_en     = 1'b0;
      rd_en      = 1'b0;
      busy       = 1'b0;
      flush_done = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = CLEAR_ON_RST ? S_CLEAR : S_RUN;
         end
         S_RUN: begin
            accept_wr = 1'b1;
            arb_en    = 1'b1;
            rd_en     = 1'b1;
            if (clear && all_empty) state_nxt = S_CLEAR;
            else if (flush)         state_nxt = S_DRAIN;
         end
         S_CLEAR: begin
            busy = 1'b1;
            if (&sweep) state_nxt = S_RUN;
         end
         S_DRAIN: begin
            busy   = 1'b1;
            arb_en = 1'b1;
            rd_en  = 1'b1;
            if (all_empty) begin
               flush_done = 1'b1;
               state_nxt  = S_RUN;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_mem_ctrl.sv
// tb_result_mem_ctrl
//    Directed scenarios plus a randomized phase for result_mem_ctrl. A
//    behavioural model (per-channel pending queues, a flat word array and a
//    mode variable) predicts every handshake, status flag and read result.
module tb_result_mem_ctrl;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 6;
   localparam int NUM_CH     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int DEPTH      = 64;
   localparam logic [15:0] CLEAR_VAL = 16'hFFFF;

   typedef enum int {M_IDLE, M_RUN, M_CLEAR, M_DRAIN} mode_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [NUM_CH-1:0]        wr_valid = '0;
   logic [NUM_CH-1:0]        wr_ready;
   logic [NUM_CH*ADDR_W-1:0] wr_addr  = '0;
   logic [NUM_CH*DATA_W-1:0] wr_data  = '0;
   logic                     rd_req   = 1'b0;
   logic [ADDR_W-1:0]        rd_addr  = '0;
   logic                     rd_valid;
   logic [DATA_W-1:0]        rd_data;
   logic                     clear    = 1'b0;
   logic                     flush    = 1'b0;
   logic                     flush_done;
   logic                     busy;
   logic [1:0]               state_dbg;

   result_mem_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
      .FIFO_DEPTH(FIFO_DEPTH), .CLEAR_VAL(CLEAR_VAL), .CLEAR_ON_RST(1'b1)
   ) dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .clear(clear), .flush(flush), .flush_done(flush_done), .busy(busy),
      .state_dbg(state_dbg)
   );

   // ---------------- scoreboard / model state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   mode_t       mode  = M_IDLE;
   int          rr    = 0;
   int          sweep = 0;
   logic [15:0] ref_mem [DEPTH];
   logic [21:0] exp_q0 [$];   // {addr,data} pending in channel 0
   logic [21:0] exp_q1 [$];   // {addr,data} pending in channel 1
   bit          exp_rv = 1'b0;
   logic [15:0] exp_rd = '0;

   bit          pushed [2];
   int          busy_cnt;
   bit          fd_seen;
   bit          ready0_low_seen;
   logic [15:0] obs_rd;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int qsize(input int ch);
      return (ch == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic void qpush(input int ch, input logic [21:0] e);
      if (ch == 0) exp_q0.push_back(e);
      else         exp_q1.push_back(e);
   endfunction

   function automatic logic [21:0] qpop(input int ch);
      if (ch == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   function automatic void model_reset();
      exp_q0.delete();
      exp_q1.delete();
      mode   = M_IDLE;
      rr     = 0;
      sweep  = 0;
      exp_rv = 1'b0;
      exp_rd = '0;
   endfunction

   // One rising edge worth of behaviour, from the pre-edge model state
   task automatic model_edge(input logic [1:0] rdy, input bit all_empty);
      bit          run_like;
      bit          granted;
      logic [21:0] e;
      int          ch;
      run_like  = (mode == M_RUN) || (mode == M_DRAIN);
      granted   = 1'b0;
      pushed[0] = 1'b0;
      pushed[1] = 1'b0;
      if (run_like) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch = (rr + i) % NUM_CH;
            if (!granted && qsize(ch) > 0) begin
               e = qpop(ch);
               ref_mem[e[21:16]] = e[15:0];
               rr = (ch + 1) % NUM_CH;
               granted = 1'b1;
            end
         end
      end
      if (mode == M_CLEAR) ref_mem[sweep] = CLEAR_VAL;
      if (rd_req && run_like) begin
         exp_rv = 1'b1;
         exp_rd = ref_mem[rd_addr];
      end else begin
         exp_rv = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_valid[c] && rdy[c]) begin
            qpush(c, {wr_addr[c*ADDR_W +: ADDR_W], wr_data[c*DATA_W +: DATA_W]});
            pushed[c] = 1'b1;
         end
      end
      case (mode)
         M_IDLE: begin
            mode  = M_CLEAR;
            sweep = 0;
         end
         M_CLEAR: begin
            if (sweep == DEPTH - 1) begin
               mode  = M_RUN;
               sweep = 0;
            end else begin
               sweep++;
            end
         end
         M_RUN: begin
            if (clear && all_empty) begin
               mode  = M_CLEAR;
               sweep = 0;
            end else if (flush) begin
               mode = M_DRAIN;
            end
         end
         default: begin
            if (all_empty) mode = M_RUN;
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      logic [1:0] exp_ready;
      bit         all_empty;
      #1;
      all_empty = (qsize(0) == 0) && (qsize(1) == 0);
      for (int c = 0; c < NUM_CH; c++) exp_ready[c] = (mode == M_RUN) && (qsize(c) < FIFO_DEPTH);
      check_eq("wr_ready", wr_ready, exp_ready);
      check_eq("busy", busy, (mode == M_CLEAR) || (mode == M_DRAIN));
      check_eq("flush_done", flush_done, (mode == M_DRAIN) && all_empty);
      if (busy)         busy_cnt++;
      if (flush_done)   fd_seen = 1'b1;
      if (!wr_ready[0]) ready0_low_seen = 1'b1;
      @(posedge clock);
      model_edge(exp_ready, all_empty);
      #1;
      check_eq("rd_valid", rd_valid, exp_rv);
      if (exp_rv) check_eq("rd_data", rd_data, exp_rd);
      obs_rd = rd_data;
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset    = 1'b0;
      wr_valid = '0;
      rd_req   = 1'b0;
      clear    = 1'b0;
      flush    = 1'b0;
      #1;
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_rd_valid", rd_valid, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_flush_done", flush_done, 0);
      check_eq("rst_busy", busy, 0);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic wait_run(input string tag);
      int guard;
      busy_cnt = 0;
      guard    = 0;
      while (mode != M_RUN && guard < 200) begin
         tick();
         guard++;
      end
      check_eq({tag, "_reach_run"}, (mode == M_RUN), 1);
      check_eq({tag, "_clear_len"}, busy_cnt, DEPTH);
   endtask

   task automatic do_flush(input string tag);
      int guard;
      flush   = 1'b1;
      fd_seen = 1'b0;
      tick();
      flush = 1'b0;
      guard = 0;
      while (!fd_seen && guard < 50) begin
         tick();
         guard++;
      end
      check_eq(tag, fd_seen, 1);
   endtask

   task automatic read_word(input logic [ADDR_W-1:0] a, output logic [15:0] d);
      rd_req  = 1'b1;
      rd_addr = a;
      tick();
      rd_req = 1'b0;
      d = obs_rd;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] d;
      int idx0, idx1, guard;
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;

      @(negedge clock);
      apply_reset();

      // Power-up sweep, then every word reads as unreached
      wait_run("s1");
      for (int a = 0; a < DEPTH; a++) begin
         read_word(ADDR_W'(a), d);
         check_eq("s1_clear_val", d, CLEAR_VAL);
      end

      // Two channels, distinct addresses, same cycle
      wr_valid = 2'b11;
      wr_addr  = {6'd9, 6'd5};
      wr_data  = {16'h0022, 16'h0011};
      tick();
      wr_valid = '0;
      do_flush("s2_flush_done");
      read_word(6'd5, d);
      check_eq("s2_addr5", d, 16'h0011);
      read_word(6'd9, d);
      check_eq("s2_addr9", d, 16'h0022);

      // Same address from both channels with rr at channel 0: ch1 commits last
      wr_valid = 2'b11;
      wr_addr  = {6'd7, 6'd7};
      wr_data  = {16'hBBBB, 16'hAAAA};
      tick();
      wr_valid = '0;
      do_flush("s3_flush_done");
      read_word(6'd7, d);
      check_eq("s3_addr7", d, 16'hBBBB);

      // Read hits the word being committed in the same cycle
      wr_valid = 2'b01;
      wr_addr  = {6'd0, 6'd3};
      wr_data  = {16'h0000, 16'h1234};
      tick();
      wr_valid = '0;
      rd_req   = 1'b1;
      rd_addr  = 6'd3;
      tick();
      rd_req = 1'b0;
      check_eq("s5_write_first", obs_rd, 16'h1234);

      // Back-to-back pushes on both channels until ch0 backs up
      ready0_low_seen = 1'b0;
      idx0  = 0;
      idx1  = 0;
      guard = 0;
      while ((idx0 < 6 || idx1 < 8) && guard < 60) begin
         wr_valid[0] = (idx0 < 6);
         wr_valid[1] = (idx1 < 8);
         wr_addr[0*ADDR_W +: ADDR_W] = ADDR_W'(16 + idx0);
         wr_data[0*DATA_W +: DATA_W] = 16'hC000 + 16'(idx0);
         wr_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(32 + idx1);
         wr_data[1*DATA_W +: DATA_W] = 16'hD000 + 16'(idx1);
         tick();
         if (pushed[0]) idx0++;
         if (pushed[1]) idx1++;
         guard++;
      end
      wr_valid = '0;
      check_eq("s4_ready0_drop", ready0_low_seen, 1);
      check_eq("s4_ch0_pushed", idx0, 6);
      check_eq("s4_ch1_pushed", idx1, 8);
      do_flush("s4_flush_done");
      for (int i = 0; i < 6; i++) begin
         read_word(ADDR_W'(16 + i), d);
         check_eq("s4_ch0_word", d, 16'hC000 + 16'(i));
      end
      for (int i = 0; i < 8; i++) begin
         read_word(ADDR_W'(32 + i), d);
         check_eq("s4_ch1_word", d, 16'hD000 + 16'(i));
      end

      // Randomized traffic with colliding addresses, flushes and clears
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_valid[c] = ($urandom_range(0, 9) < 6);
            wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
            wr_data[c*DATA_W +: DATA_W] = 16'($urandom_range(0, 16'hFFFF));
         end
         rd_req  = ($urandom_range(0, 1) == 1);
         rd_addr = ADDR_W'($urandom_range(0, 15));
         clear   = ($urandom_range(0, 149) == 0);
         flush   = ($urandom_range(0, 29) == 0);
         tick();
      end
      wr_valid = '0;
      rd_req   = 1'b0;
      clear    = 1'b0;
      flush    = 1'b0;
      guard    = 0;
      while (mode != M_RUN && guard < 100) begin
         tick();
         guard++;
      end
      check_eq("rand_settle", (mode == M_RUN), 1);
      do_flush("rand_flush_done");
      for (int a = 0; a < 16; a++) read_word(ADDR_W'(a), d);

      // Reset with writes pending, then reset again in the middle of CLEAR
      idx0  = 0;
      guard = 0;
      while ((qsize(0) + qsize(1)) < 3 && guard < 20) begin
         wr_valid = 2'b11;
         wr_addr[0*ADDR_W +: ADDR_W] = ADDR_W'(40 + idx0);
         wr_data[0*DATA_W +: DATA_W] = 16'hE000 + 16'(idx0);
         wr_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(48 + idx0);
         wr_data[1*DATA_W +: DATA_W] = 16'hF000 + 16'(idx0);
         tick();
         idx0++;
         guard++;
      end
      check_eq("s6_pending", (qsize(0) + qsize(1)) >= 3, 1);
      apply_reset();
      for (int i = 0; i < 20; i++) tick();
      check_eq("s6_mid_clear_busy", busy, 1);
      apply_reset();
      wait_run("s6");
      do_flush("s6_flush_done");
      for (int i = 0; i < 8; i++) begin
         read_word(ADDR_W'(40 + i), d);
         check_eq("s6_discard_ch0", d, CLEAR_VAL);
         read_word(ADDR_W'(48 + i), d);
         check_eq("s6_discard_ch1", d, CLEAR_VAL);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
